// File: rtl/bus_dev_endpoint.sv
// Broadcast-bus device endpoint: TX FIFO toward the arbiter, filtered RX FIFO toward the host.
// Optional statistics counters are enabled by defining BUS_EP_STATS_EN.

module bus_dev_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem[wr_ptr] <= wr_data;
    end

    assign valid = (count != '0);
    assign full  = (count == CW'(DEPTH));
    assign head  = valid ? mem[rd_ptr] : '0;
endmodule

module bus_dev_endpoint #(
    parameter int         PCKG_SZ   = 16,
    parameter int         DEPTH     = 8,
    parameter logic [7:0] ID        = 8'h00,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [PCKG_SZ-1:0] tx_data,
    output logic               tx_full,
    output logic               pndng,
    output logic [PCKG_SZ-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [PCKG_SZ-1:0] D_push,
    output logic               rx_valid,
    output logic [PCKG_SZ-1:0] rx_data,
    input  logic               rx_rd,
    input  logic               clr_flags,
    output logic               tx_ovf,
    output logic               rx_ovf,
    output logic               rx_misrt
`ifdef BUS_EP_STATS_EN
    ,
    output logic [15:0]        tx_sent_cnt,
    output logic [15:0]        rx_recv_cnt
`endif
);
    logic       tx_pop_en;
    logic       tx_wr_en;
    logic       tx_ovf_set;
    logic [7:0] dest;
    logic       rx_accept;
    logic       rx_full;
    logic       rx_rd_en;
    logic       rx_wr_en;
    logic       rx_ovf_set;
    logic       rx_mis_set;

    assign tx_pop_en  = pop & pndng;
    // A pop on a full FIFO frees the slot the write lands in.
    assign tx_wr_en   = tx_wr & (~tx_full | pop);
    assign tx_ovf_set = tx_wr & tx_full & ~pop;

    assign dest       = D_push[PCKG_SZ-1 -: 8];
    assign rx_accept  = (dest == ID) || (dest == BROADCAST);
    assign rx_rd_en   = rx_rd & rx_valid;
    assign rx_wr_en   = push & rx_accept & (~rx_full | rx_rd);
    assign rx_ovf_set = push & rx_accept & rx_full & ~rx_rd;
    assign rx_mis_set = push & ~rx_accept;

    bus_dev_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_tx (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_wr_en),
        .wr_data (tx_data),
        .rd_en   (tx_pop_en),
        .head    (D_pop),
        .valid   (pndng),
        .full    (tx_full)
    );

    bus_dev_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_wr_en),
        .wr_data (D_push),
        .rd_en   (rx_rd_en),
        .head    (rx_data),
        .valid   (rx_valid),
        .full    (rx_full)
    );

    // A setting event in the same cycle as clr_flags keeps the flag high.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf   <= 1'b0;
            rx_ovf   <= 1'b0;
            rx_misrt <= 1'b0;
        end else begin
            tx_ovf   <= tx_ovf_set | (tx_ovf   & ~clr_flags);
            rx_ovf   <= rx_ovf_set | (rx_ovf   & ~clr_flags);
            rx_misrt <= rx_mis_set | (rx_misrt & ~clr_flags);
        end
    end

`ifdef BUS_EP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || clr_flags) begin
            tx_sent_cnt <= '0;
            rx_recv_cnt <= '0;
        end else begin
            if (tx_pop_en && tx_sent_cnt != 16'hFFFF)
                tx_sent_cnt <= tx_sent_cnt + 16'd1;
            if (rx_wr_en && rx_recv_cnt != 16'hFFFF)
                rx_recv_cnt <= rx_recv_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Bench for bus_dev_endpoint: directed vector table, corner sequences, random vs queue model.
module tb_bus_dev_endpoint;
    localparam int         W    = 16;
    localparam int         D    = 8;
    localparam logic [7:0] MYID = 8'h02;

    logic         clk = 1'b0;
    logic         reset, tx_wr, pop, push, rx_rd, clr_flags;
    logic [W-1:0] tx_data, D_push;
    logic         tx_full, pndng, rx_valid, tx_ovf, rx_ovf, rx_misrt;
    logic [W-1:0] D_pop, rx_data;
`ifdef BUS_EP_STATS_EN
    logic [15:0]  tx_sent_cnt, rx_recv_cnt;
`endif

    bus_dev_endpoint #(.PCKG_SZ(W), .DEPTH(D), .ID(MYID), .BROADCAST(8'hFF)) dut (
        .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data),
        .tx_full(tx_full), .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_rd(rx_rd), .clr_flags(clr_flags), .tx_ovf(tx_ovf),
        .rx_ovf(rx_ovf), .rx_misrt(rx_misrt)
`ifdef BUS_EP_STATS_EN
        , .tx_sent_cnt(tx_sent_cnt), .rx_recv_cnt(rx_recv_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] txq[$];
    logic [W-1:0] rxq[$];
    logic         m_txo = 1'b0, m_rxo = 1'b0, m_mis = 1'b0;

    typedef struct {
        logic         rst, wr;
        logic [15:0]  td;
        logic         pp, ps;
        logic [15:0]  dp;
        logic         rd, clr;
        logic [37:0]  exp;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [37:0] ev(logic full, logic pn, logic [15:0] dpop,
                                       logic rv, logic [15:0] rd,
                                       logic to, logic ro, logic mi);
        return {full, pn, dpop, rv, rd, to, ro, mi};
    endfunction

    function automatic logic [37:0] dut_vec();
        return {tx_full, pndng, D_pop, rx_valid, rx_data, tx_ovf, rx_ovf, rx_misrt};
    endfunction

    function automatic logic [37:0] model_vec();
        logic [W-1:0] th, rh;
        th = (txq.size() != 0) ? txq[0] : '0;
        rh = (rxq.size() != 0) ? rxq[0] : '0;
        return {txq.size() == D, txq.size() != 0, th,
                rxq.size() != 0, rh, m_txo, m_rxo, m_mis};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Next state from the packet rules, applied to the inputs present before the edge.
    task automatic model_step();
        int  ts, rs;
        bit  tpop, twr, tov, acc, rrd, rwr, rov, mis;
        if (reset) begin
            txq.delete();
            rxq.delete();
            m_txo = 0; m_rxo = 0; m_mis = 0;
            return;
        end
        ts   = txq.size();
        tpop = pop && ts > 0;
        twr  = tx_wr && (ts < D || pop);
        tov  = tx_wr && ts == D && !pop;
        if (tpop) void'(txq.pop_front());
        if (twr) txq.push_back(tx_data);
        rs   = rxq.size();
        acc  = (D_push[15:8] == MYID) || (D_push[15:8] == 8'hFF);
        mis  = push && !acc;
        rrd  = rx_rd && rs > 0;
        rwr  = push && acc && (rs < D || rx_rd);
        rov  = push && acc && rs == D && !rx_rd;
        if (rrd) void'(rxq.pop_front());
        if (rwr) rxq.push_back(D_push);
        m_txo = tov ? 1'b1 : (clr_flags ? 1'b0 : m_txo);
        m_rxo = rov ? 1'b1 : (clr_flags ? 1'b0 : m_rxo);
        m_mis = mis ? 1'b1 : (clr_flags ? 1'b0 : m_mis);
    endtask

    task automatic cyc(string name);
        model_step();
        @(posedge clk);
        #1;
        chk(name, 64'(dut_vec()), 64'(model_vec()));
    endtask

    task automatic idle();
        reset = 0; tx_wr = 0; pop = 0; push = 0; rx_rd = 0; clr_flags = 0;
        tx_data = '0; D_push = '0;
    endtask

    logic [W-1:0] exp_q[$];
    logic [7:0]   dst;

    initial begin
        idle();
        tbl[0]  = '{1, 0, 16'h0,    0, 0, 16'h0,    0, 0, ev(0, 0, 16'h0,    0, 16'h0,    0, 0, 0)};
        tbl[1]  = '{0, 1, 16'h0312, 0, 0, 16'h0,    0, 0, ev(0, 1, 16'h0312, 0, 16'h0,    0, 0, 0)};
        tbl[2]  = '{0, 0, 16'h0,    1, 0, 16'h0,    0, 0, ev(0, 0, 16'h0,    0, 16'h0,    0, 0, 0)};
        tbl[3]  = '{0, 0, 16'h0,    0, 1, 16'h02AB, 0, 0, ev(0, 0, 16'h0,    1, 16'h02AB, 0, 0, 0)};
        tbl[4]  = '{0, 0, 16'h0,    0, 1, 16'hFF01, 0, 0, ev(0, 0, 16'h0,    1, 16'h02AB, 0, 0, 0)};
        tbl[5]  = '{0, 0, 16'h0,    0, 0, 16'h0,    1, 0, ev(0, 0, 16'h0,    1, 16'hFF01, 0, 0, 0)};
        tbl[6]  = '{0, 0, 16'h0,    0, 0, 16'h0,    1, 0, ev(0, 0, 16'h0,    0, 16'h0,    0, 0, 0)};
        tbl[7]  = '{0, 0, 16'h0,    0, 1, 16'h0355, 0, 0, ev(0, 0, 16'h0,    0, 16'h0,    0, 0, 1)};
        tbl[8]  = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 1, ev(0, 0, 16'h0,    0, 16'h0,    0, 0, 0)};
        tbl[9]  = '{0, 0, 16'h0,    0, 1, 16'h0355, 0, 1, ev(0, 0, 16'h0,    0, 16'h0,    0, 0, 1)};
        tbl[10] = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 1, ev(0, 0, 16'h0,    0, 16'h0,    0, 0, 0)};

        for (int i = 0; i < 11; i++) begin
            reset = tbl[i].rst; tx_wr = tbl[i].wr; tx_data = tbl[i].td;
            pop = tbl[i].pp; push = tbl[i].ps; D_push = tbl[i].dp;
            rx_rd = tbl[i].rd; clr_flags = tbl[i].clr;
            cyc($sformatf("model_vec%0d", i));
            chk($sformatf("table_vec%0d", i), 64'(dut_vec()), 64'(tbl[i].exp));
        end
        idle();

        // TX overflow: nine writes into an eight-deep FIFO.
        for (int i = 0; i < 9; i++) begin
            tx_wr = 1; tx_data = 16'h1000 + 16'(i);
            cyc("fill_tx");
        end
        idle();
        chk("t4_tx_full", tx_full, 1);
        chk("t4_tx_ovf", tx_ovf, 1);
        clr_flags = 1;
        cyc("clr");
        idle();
        chk("t4_ovf_cleared", tx_ovf, 0);

        // Write and pop together while full.
        tx_wr = 1; pop = 1; tx_data = 16'hABCD;
        cyc("full_wr_pop");
        idle();
        chk("t5_ovf", tx_ovf, 0);
        chk("t5_full", tx_full, 1);
        chk("t5_head", D_pop, 16'h1001);
        for (int i = 1; i < 8; i++) exp_q.push_back(16'h1000 + 16'(i));
        exp_q.push_back(16'hABCD);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t5_drain%0d", i), D_pop, exp_q[i]);
            pop = 1;
            cyc("drain");
        end
        idle();
        chk("t5_empty", pndng, 0);
        pop = 1;
        cyc("pop_empty");
        idle();
        chk("t5_pop_empty_pndng", pndng, 0);
        chk("t5_pop_empty_ovf", tx_ovf, 0);

        // Write and pop together while empty: write lands.
        tx_wr = 1; pop = 1; tx_data = 16'h7777;
        cyc("empty_wr_pop");
        idle();
        chk("empty_wr_pop_head", D_pop, 16'h7777);

        // Reset with RX entries and a push in flight.
        for (int i = 1; i <= 3; i++) begin
            push = 1; D_push = 16'h0200 + 16'(i);
            cyc("fill_rx");
        end
        idle();
        chk("t6_rx_valid_pre", rx_valid, 1);
        reset = 1; push = 1; D_push = 16'h0204;
        cyc("reset_push");
        idle();
        chk("t6_rx_valid", rx_valid, 0);
        chk("t6_pndng", pndng, 0);
        chk("t6_rx_data", rx_data, 0);
`ifdef BUS_EP_STATS_EN
        chk("t6_tx_cnt", tx_sent_cnt, 0);
        chk("t6_rx_cnt", rx_recv_cnt, 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            tx_wr     = ($urandom_range(0, 99) < 50);
            tx_data   = 16'($urandom);
            pop       = ($urandom_range(0, 99) < 40);
            push      = ($urandom_range(0, 99) < 50);
            rx_rd     = ($urandom_range(0, 99) < 35);
            clr_flags = ($urandom_range(0, 99) < 5);
            case ($urandom_range(0, 3))
                0, 1:    dst = MYID;
                2:       dst = 8'hFF;
                default: dst = 8'($urandom);
            endcase
            D_push = {dst, 8'($urandom)};
            cyc("random");
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
